// File: rtl/simon_playback_ctrl.sv
// -----------------------------------------------------------------------------
// simon_playback_ctrl
//
// Plays a Simon "show me" pattern. On start it latches the tick rate, seed and
// pattern length, then steps through seq_len pseudo-random colours drawn from
// a 16-bit Galois LFSR. Each colour is shown as a one-hot LED with a square-wave
// tone for ON_MS milliseconds, followed by GAP_MS milliseconds of silence.
//
// Ports
//   clk              in   system clock
//   rst_n            in   asynchronous active-low reset
//   ticks_per_milli  in   clock cycles per millisecond (latched at start, 0 -> 1)
//   start            in   level-sampled start request, honoured only when idle
//   abort            in   return to idle on the next edge from any active state
//   seed             in   LFSR seed (latched at start, 0 -> 16'hACE1)
//   seq_len          in   number of steps to play (latched at start)
//   busy             out  high in LOAD, ON and GAP
//   done             out  one-cycle pulse after the final gap
//   led              out  one-hot colour during ON, else 0
//   sound            out  square-wave tone during ON, else 0
//   step_idx         out  0-based index of the step being played
//
// State table
//   IDLE | waiting for start; latches tpm, seed and seq_len
//   LOAD | one cycle: seed the LFSR, clear step_idx
//   ON   | LED and tone for ON_MS milliseconds
//   GAP  | dark and silent for GAP_MS milliseconds
//   DONE | one cycle: done pulse
// -----------------------------------------------------------------------------
module simon_playback_ctrl #(
    parameter int ON_MS  = 300,
    parameter int GAP_MS = 100,
    parameter int LEN_W  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      ticks_per_milli,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      seed,
    input  logic [LEN_W-1:0] seq_len,
    output logic             busy,
    output logic             done,
    output logic [3:0]       led,
    output logic             sound,
    output logic [LEN_W-1:0] step_idx
);

    localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ON,
        S_GAP,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [15:0]      tpm_q;
    logic [15:0]      seed_q;
    logic [LEN_W-1:0] len_q;
    logic [15:0]      lfsr;
    logic [15:0]      cyc_cnt;
    logic [15:0]      ms_cnt;
    logic [15:0]      tone_cnt;
    logic             tone;

    logic [15:0]      tpm_eff;
    logic             ms_tick;
    logic             on_end;
    logic             gap_end;
    logic [LEN_W:0]   idx_inc;
    logic             more_steps;
    logic [2:0]       hp_shift;
    logic [15:0]      hp_raw;
    logic [15:0]      hp;

    assign tpm_eff    = (tpm_q == 16'd0) ? 16'd1 : tpm_q;
    assign ms_tick    = (cyc_cnt == tpm_eff - 16'd1);
    assign on_end     = ms_tick && (ms_cnt == 16'(ON_MS - 1));
    assign gap_end    = ms_tick && (ms_cnt == 16'(GAP_MS - 1));

    // One extra bit so the comparison stays correct at the maximum length.
    assign idx_inc    = {1'b0, step_idx} + {{LEN_W{1'b0}}, 1'b1};
    assign more_steps = idx_inc < {1'b0, len_q};

    // Half-period shrinks by a factor of two per colour; 3 bits so colour 3 shifts by 4.
    assign hp_shift   = {1'b0, lfsr[1:0]} + 3'd1;
    assign hp_raw     = tpm_eff >> hp_shift;
    assign hp         = (hp_raw == 16'd0) ? 16'd1 : hp_raw;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start && !abort) state_next = S_LOAD;
            S_LOAD: state_next = (len_q == '0) ? S_DONE : S_ON;
            S_ON:   if (on_end) state_next = S_GAP;
            S_GAP:  if (gap_end) state_next = more_steps ? S_ON : S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (abort && (state != S_IDLE)) begin
            state_next = S_IDLE;
        end
    end

    // Outputs
    always_comb begin
        busy  = (state == S_LOAD) || (state == S_ON) || (state == S_GAP);
        done  = (state == S_DONE);
        led   = 4'b0000;
        sound = 1'b0;
        if (state == S_ON) begin
            led   = 4'b0001 << lfsr[1:0];
            sound = tone;
        end
    end

    // Datapath: latches, LFSR, step index, millisecond timebase and tone divider.
    // Updates key off the actual transition so an abort suppresses all of them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tpm_q    <= 16'd0;
            seed_q   <= 16'd0;
            len_q    <= '0;
            lfsr     <= LFSR_DEFAULT;
            step_idx <= '0;
            cyc_cnt  <= 16'd0;
            ms_cnt   <= 16'd0;
            tone_cnt <= 16'd0;
            tone     <= 1'b0;
        end else begin
            if ((state == S_IDLE) && (state_next == S_LOAD)) begin
                tpm_q  <= ticks_per_milli;
                seed_q <= seed;
                len_q  <= seq_len;
            end

            if ((state == S_LOAD) && (state_next != S_IDLE)) begin
                lfsr     <= (seed_q == 16'd0) ? LFSR_DEFAULT : seed_q;
                step_idx <= '0;
            end

            if ((state == S_ON) && (state_next == S_GAP)) begin
                lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
            end

            if ((state == S_GAP) && (state_next != S_GAP) && (state_next != S_IDLE)) begin
                step_idx <= idx_inc[LEN_W-1:0];
            end

            // Every state change restarts both the ms timebase and the tone phase.
            if (state_next != state) begin
                cyc_cnt <= 16'd0;
                ms_cnt  <= 16'd0;
            end else if ((state == S_ON) || (state == S_GAP)) begin
                if (ms_tick) begin
                    cyc_cnt <= 16'd0;
                    ms_cnt  <= ms_cnt + 16'd1;
                end else begin
                    cyc_cnt <= cyc_cnt + 16'd1;
                end
            end

            if (state_next != state) begin
                tone_cnt <= 16'd0;
                tone     <= 1'b0;
            end else if (state == S_ON) begin
                if (tone_cnt == hp - 16'd1) begin
                    tone_cnt <= 16'd0;
                    tone     <= ~tone;
                end else begin
                    tone_cnt <= tone_cnt + 16'd1;
                end
            end
        end
    end

endmodule
